action_string_decoder: RTL and testbench

ACTION_STRING_DECODER -- requirements
Module: action_string_decoder

---
 rtl/action_string_if.sv | 20 ++
 rtl/action_string_decoder.sv | 89 ++++++++
 tb/tb_action_string_decoder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/action_string_if.sv
// action_string_if: request/response bundle between an action-string producer and the decoder.
interface action_string_if;
  logic [63:0] action_string;
  logic        go;
  logic        ready;
  logic [2:0]  code;
  logic        valid;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  count;
  modport master (
    output action_string, go, ready,
    input  code, valid, busy, done, error, count
  );
  modport slave (
    input  action_string, go, ready,
    output code, valid, busy, done, error, count
  );
endinterface

// File: rtl/action_string_decoder.sv
// action_string_decoder: serially decodes unary-run action symbols (N ones then a zero) from a 64-bit string.
module action_string_decoder (
  input logic            clock,
  input logic            reset,
  action_string_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SCAN, EMIT, DONE, ERR} state_t;
  state_t      state;
  logic [63:0] sr;
  logic [6:0]  idx;
  logic [2:0]  run;
  logic [2:0]  code;
  logic        valid;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  count;
  logic        last;
  assign last = idx == 7'd63;
  assign bus.code  = code;
  assign bus.valid = valid;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.error = error;
  assign bus.count = count;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      idx   <= '0;
      run   <= '0;
      code  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.go) begin
          sr    <= bus.action_string;
          idx   <= '0;
          run   <= '0;
          count <= '0;
          error <= 1'b0;
          busy  <= 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          sr  <= {sr[62:0], 1'b0};
          idx <= idx + 7'd1;
          if (sr[63]) begin
            // a fifth one or a run still open at bit 0 cannot form a symbol
            if (run == 3'd4 || last) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ERR;
            end else begin
              run <= run + 3'd1;
            end
          end else if (run != 3'd0) begin
            code  <= run;
            valid <= 1'b1;
            run   <= '0;
            state <= EMIT;
          end else if (last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        EMIT: if (bus.ready) begin
          code  <= '0;
          valid <= 1'b0;
          count <= count + 6'd1;
          if (idx[6]) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_action_string_decoder.sv
// tb_action_string_decoder: randomized and directed checks of the decoder against a symbol-list model.
module tb_action_string_decoder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  action_string_if bus ();
  action_string_decoder dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int checks = 0;
  int errors = 0;
  logic [127:0] got_pack, exp_pack;
  int n_hs, exp_n, done_pulses, first_valid, first_done, first_err, first_hs;
  bit exp_err, fin_err, timed_out, hold_ok, zero_ok, err_before, err_at_start;
  int fin_count;
  // Expected symbol sequence: each code is appended as one nibble, in emission order
  task automatic model(input logic [63:0] s);
    int r;
    r = 0;
    exp_pack = '0;
    exp_n = 0;
    exp_err = 0;
    for (int i = 63; i >= 0 && !exp_err; i--) begin
      if (s[i]) begin
        r++;
        if (r == 5 || i == 0) exp_err = 1;
      end else if (r > 0) begin
        exp_pack = (exp_pack << 4) | 128'(r);
        exp_n++;
        r = 0;
      end
    end
  endtask
  function automatic logic [63:0] gen_string();
    logic [63:0] s;
    int len, n, g;
    if ($urandom_range(3) == 0) return {$urandom, $urandom};
    s = '0;
    len = 0;
    for (int k = 0; k < 40; k++) begin
      n = ($urandom_range(9) == 0) ? 5 : $urandom_range(4, 1);
      g = $urandom_range(3);
      if (len + n + 1 + g > 64) break;
      s = (s << (n + 1 + g)) | (((64'd1 << n) - 64'd1) << (1 + g));
      len += n + 1 + g;
    end
    if ($urandom_range(7) == 0 && len < 64) s = (s << 1) | 64'd1;
    return s;
  endfunction
  task automatic drive_string(input logic [63:0] s, input int pct, input int hold);
    int h;
    bit pv, pr, fin;
    logic [2:0] pc;
    got_pack = '0; n_hs = 0; done_pulses = 0;
    first_valid = -1; first_done = -1; first_err = -1; first_hs = -1;
    hold_ok = 1; zero_ok = 1; fin = 0; h = hold; pv = 0; pr = 0; pc = '0;
    @(negedge clock);
    err_before = bus.error;
    bus.action_string = s;
    bus.go = 1'b1;
    bus.ready = 1'b0;
    for (int c = 1; c <= 3000 && !fin; c++) begin
      @(negedge clock);
      bus.go = bus.busy && ($urandom_range(7) == 0);
      bus.action_string = {$urandom, $urandom};
      if (c == 1) err_at_start = bus.error;
      if (bus.valid && first_valid < 0) first_valid = c;
      if (bus.error && first_err < 0) first_err = c;
      if (bus.done) begin
        done_pulses++;
        if (first_done < 0) first_done = c;
      end
      if (pv && !pr && (!bus.valid || bus.code !== pc)) hold_ok = 0;
      if (!bus.valid && bus.code !== 3'd0) zero_ok = 0;
      bus.ready = ($urandom_range(99) < pct);
      if (bus.valid && h > 0) begin
        bus.ready = 1'b0;
        h--;
      end
      if (bus.valid && bus.ready) begin
        got_pack = (got_pack << 4) | 128'(bus.code);
        n_hs++;
        if (first_hs < 0) first_hs = c;
      end
      pv = bus.valid; pr = bus.ready; pc = bus.code;
      if (!bus.busy) fin = 1;
    end
    timed_out = !fin;
    bus.go = 1'b0;
    bus.ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (bus.done) done_pulses++;
    end
    fin_err = bus.error;
    fin_count = bus.count;
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({bus.code, bus.valid, bus.busy, bus.done, bus.error, bus.count} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {bus.code, bus.valid, bus.busy, bus.done, bus.error, bus.count});
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_wait: busy %b valid %b expected 0 0", bus.busy, bus.valid);
    end
  endtask
  task automatic test_empty();
    drive_string(64'h0, 100, 0);
    checks++;
    if (first_done !== 65 || done_pulses !== 1) begin
      errors++;
      $display("FAIL empty_done: cycle %0d pulses %0d expected 65 1", first_done, done_pulses);
    end
    checks++;
    if (fin_count !== 0 || first_valid !== -1 || fin_err !== 1'b0) begin
      errors++;
      $display("FAIL empty_outputs: count %0d first_valid %0d error %b expected 0 -1 0", fin_count, first_valid, fin_err);
    end
  endtask
  task automatic test_single();
    drive_string(64'h2, 100, 0);
    checks++;
    if (first_valid !== 65 || got_pack !== 128'h1) begin
      errors++;
      $display("FAIL single_code: valid cycle %0d codes %h expected 65 1", first_valid, got_pack);
    end
    checks++;
    if (fin_count !== 1 || done_pulses !== 1 || first_done !== 66 || fin_err !== 1'b0) begin
      errors++;
      $display("FAIL single_end: count %0d pulses %0d done cycle %0d error %b expected 1 1 66 0", fin_count, done_pulses, first_done, fin_err);
    end
  endtask
  task automatic test_multi();
    drive_string(64'h1DA, 100, 0);
    checks++;
    if (got_pack !== 128'h321 || fin_count !== 3) begin
      errors++;
      $display("FAIL multi_codes: codes %h count %0d expected 321 3", got_pack, fin_count);
    end
    checks++;
    if (done_pulses !== 1 || fin_err !== 1'b0 || !zero_ok) begin
      errors++;
      $display("FAIL multi_end: pulses %0d error %b code_zero_ok %b expected 1 0 1", done_pulses, fin_err, zero_ok);
    end
  endtask
  task automatic test_backpressure();
    drive_string(64'h1DA, 100, 10);
    checks++;
    if (!hold_ok || first_hs !== first_valid + 10) begin
      errors++;
      $display("FAIL hold_stable: hold_ok %b handshake cycle %0d expected 1 %0d", hold_ok, first_hs, first_valid + 10);
    end
    checks++;
    if (got_pack !== 128'h321 || fin_count !== 3 || done_pulses !== 1) begin
      errors++;
      $display("FAIL hold_sequence: codes %h count %0d pulses %0d expected 321 3 1", got_pack, fin_count, done_pulses);
    end
  endtask
  task automatic test_errors();
    drive_string(64'h3E, 100, 0);
    checks++;
    if (fin_err !== 1'b1 || first_valid !== -1 || fin_count !== 0 || done_pulses !== 0) begin
      errors++;
      $display("FAIL run_of_five: error %b first_valid %0d count %0d pulses %0d expected 1 -1 0 0", fin_err, first_valid, fin_count, done_pulses);
    end
    drive_string(64'h1, 100, 0);
    checks++;
    if (fin_err !== 1'b1 || first_err !== 65 || done_pulses !== 0) begin
      errors++;
      $display("FAIL unterminated: error %b cycle %0d pulses %0d expected 1 65 0", fin_err, first_err, done_pulses);
    end
    drive_string(64'h2, 100, 0);
    checks++;
    if (err_before !== 1'b1 || err_at_start !== 1'b0 || fin_err !== 1'b0 || got_pack !== 128'h1) begin
      errors++;
      $display("FAIL error_clear: before %b after_go %b final %b codes %h expected 1 0 0 1", err_before, err_at_start, fin_err, got_pack);
    end
  endtask
  task automatic test_reset_mid();
    int w;
    @(negedge clock);
    bus.action_string = 64'h1DA;
    bus.go = 1'b1;
    bus.ready = 1'b1;
    @(negedge clock);
    bus.go = 1'b0;
    repeat (20) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.code, bus.valid, bus.busy, bus.done, bus.error, bus.count} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_scan: got %h expected 0", {bus.code, bus.valid, bus.busy, bus.done, bus.error, bus.count});
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.count !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_scan_idle: busy %b count %0d expected 0 0", bus.busy, bus.count);
    end
    drive_string(64'h2, 100, 0);
    checks++;
    if (first_valid !== 65 || got_pack !== 128'h1 || fin_count !== 1 || done_pulses !== 1) begin
      errors++;
      $display("FAIL reset_then_go: valid cycle %0d codes %h count %0d pulses %0d expected 65 1 1 1", first_valid, got_pack, fin_count, done_pulses);
    end
    @(negedge clock);
    bus.action_string = 64'h2;
    bus.go = 1'b1;
    bus.ready = 1'b0;
    @(negedge clock);
    bus.go = 1'b0;
    w = 0;
    while (!bus.valid && w < 100) begin
      @(negedge clock);
      w++;
    end
    bus.ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (w >= 100 || bus.valid !== 1'b0 || bus.code !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_emit: wait %0d valid %b code %0d expected <100 0 0", w, bus.valid, bus.code);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    bus.ready = 1'b0;
    checks++;
    if (bus.count !== 6'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_emit_drop: count %0d done %b busy %b expected 0 0 0", bus.count, bus.done, bus.busy);
    end
  endtask
  task automatic test_back_to_back();
    int done_c, w;
    bit b66, b67;
    done_c = -1; b66 = 1'b1; b67 = 1'b0;
    @(negedge clock);
    bus.action_string = 64'h0;
    bus.go = 1'b1;
    bus.ready = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clock);
      if (bus.done && done_c < 0) done_c = c;
      if (c == 66) b66 = bus.busy;
      if (c == 67) b67 = bus.busy;
    end
    bus.go = 1'b0;
    checks++;
    if (done_c !== 65 || b66 !== 1'b0 || b67 !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: done cycle %0d busy66 %b busy67 %b expected 65 0 1", done_c, b66, b67);
    end
    w = 0;
    while (!bus.done && w < 200) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (w >= 200) begin
      errors++;
      $display("FAIL back_to_back_second: waited %0d cycles without done, expected < 200", w);
    end
    repeat (2) @(negedge clock);
  endtask
  task automatic test_random();
    logic [63:0] s;
    int pct;
    for (int it = 0; it < 30; it++) begin
      s = gen_string();
      pct = $urandom_range(100, 30);
      model(s);
      drive_string(s, pct, 0);
      checks++;
      if (got_pack !== exp_pack || timed_out) begin
        errors++;
        $display("FAIL random_codes[%0d] s=%h: codes %h timeout %b expected %h 0", it, s, got_pack, timed_out, exp_pack);
      end
      checks++;
      if (fin_err !== exp_err || fin_count !== exp_n || done_pulses !== (exp_err ? 0 : 1)) begin
        errors++;
        $display("FAIL random_end[%0d] s=%h: error %b count %0d pulses %0d expected %b %0d %0d", it, s, fin_err, fin_count, done_pulses, exp_err, exp_n, exp_err ? 0 : 1);
      end
      checks++;
      if (!hold_ok || !zero_ok) begin
        errors++;
        $display("FAIL random_hold[%0d] s=%h: hold_ok %b code_zero_ok %b expected 1 1", it, s, hold_ok, zero_ok);
      end
    end
  endtask
  initial begin
    bus.action_string = '0;
    bus.go = 1'b0;
    bus.ready = 1'b0;
    test_reset();
    test_empty();
    test_single();
    test_multi();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
